// File: rtl/apuf_eval_ctrl_pkg.sv
// Shared defaults and types for the arbiter-PUF evaluation sequencer.
package apuf_eval_ctrl_pkg;

    localparam int unsigned C_LENGTH_DEF       = 64;
    localparam int unsigned NUM_EVAL_DEF       = 15;
    localparam int unsigned SETTLE_CYCLES_DEF  = 4;
    localparam int unsigned PULSE_CYCLES_DEF   = 8;
    localparam int unsigned RECOVER_CYCLES_DEF = 8;

    // SAMPLE always lasts two cycles to cover the response synchronizer.
    localparam int unsigned SAMPLE_CYCLES = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_FIRE,
        ST_SAMPLE,
        ST_RECOVER,
        ST_DONE
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/apuf_eval_ctrl_sync.sv
// 1-bit two-flop synchronizer, reusable for any asynchronous single-bit input.
module sync_2ff (
    input  logic iclk,
    input  logic irst,
    input  logic id,
    output logic oq
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge iclk) begin
        if (irst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= id;
            sync_q <= meta_q;
        end
    end

    assign oq = sync_q;

endmodule

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation sequencer: latch challenge, settle, fire NUM_EVAL
// launch pulses, sample the arbiter each time and report a majority vote.
module apuf_eval_ctrl
    import apuf_eval_ctrl_pkg::*;
#(
    parameter int unsigned C_LENGTH       = C_LENGTH_DEF,
    parameter int unsigned NUM_EVAL       = NUM_EVAL_DEF,
    parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
    parameter int unsigned PULSE_CYCLES   = PULSE_CYCLES_DEF,
    parameter int unsigned RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
    input  logic                          iclk,
    input  logic                          irst,
    input  logic                          istart,
    input  logic                          iabort,
    input  logic [2*C_LENGTH-1:0]         ichallenge,
    input  logic                          iresp,
    output logic                          opulse,
    output logic [2*C_LENGTH-1:0]         ochallenge,
    output logic                          obusy,
    output logic                          ovalid,
    output logic                          oresp,
    output logic [$clog2(NUM_EVAL+1)-1:0] oones
);

    localparam int unsigned CW   = $clog2(NUM_EVAL + 1);
    localparam int unsigned PMAX = max_u(max_u(SETTLE_CYCLES, PULSE_CYCLES),
                                         max_u(RECOVER_CYCLES, SAMPLE_CYCLES));
    localparam int unsigned PW   = $clog2(PMAX + 1);

    state_e                state_q, state_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [CW-1:0]         ones_q, ones_d;
    logic [CW-1:0]         eval_q, eval_d;
    logic                  pulse_q, pulse_d;
    logic                  busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic                  resp_q, resp_d;
    logic [CW-1:0]         oones_q, oones_d;
    logic [2*C_LENGTH-1:0] chal_q, chal_d;
    logic                  resp_s;
    logic                  phase_last;

    sync_2ff u_resp_sync (
        .iclk (iclk),
        .irst (irst),
        .id   (iresp),
        .oq   (resp_s)
    );

    assign phase_last = (phase_q == '0);

    // phase_q counts down the remaining cycles of the current state.
    always_comb begin
        state_d = state_q;
        phase_d = phase_last ? phase_q : phase_q - PW'(1);
        ones_d  = ones_q;
        eval_d  = eval_q;
        pulse_d = pulse_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        resp_d  = resp_q;
        oones_d = oones_q;
        chal_d  = chal_q;

        unique case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (istart && !iabort) begin
                    chal_d  = ichallenge;
                    ones_d  = '0;
                    eval_d  = '0;
                    phase_d = PW'(SETTLE_CYCLES - 1);
                    busy_d  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: if (phase_last) begin
                phase_d = PW'(PULSE_CYCLES - 1);
                pulse_d = 1'b1;
                state_d = ST_FIRE;
            end
            ST_FIRE: if (phase_last) begin
                phase_d = PW'(SAMPLE_CYCLES - 1);
                state_d = ST_SAMPLE;
            end
            ST_SAMPLE: if (phase_last) begin
                ones_d  = ones_q + CW'(resp_s);
                eval_d  = eval_q + CW'(1);
                phase_d = PW'(RECOVER_CYCLES - 1);
                pulse_d = 1'b0;
                state_d = ST_RECOVER;
            end
            ST_RECOVER: if (phase_last) begin
                if (eval_q < CW'(NUM_EVAL)) begin
                    phase_d = PW'(PULSE_CYCLES - 1);
                    pulse_d = 1'b1;
                    state_d = ST_FIRE;
                end else begin
                    valid_d = 1'b1;
                    resp_d  = (ones_q > CW'(NUM_EVAL / 2));
                    oones_d = ones_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything except the held challenge and results.
        if (iabort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            phase_d = '0;
            pulse_d = 1'b0;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            resp_d  = resp_q;
            oones_d = oones_q;
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            ones_q  <= '0;
            eval_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            resp_q  <= 1'b0;
            oones_q <= '0;
            chal_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ones_q  <= ones_d;
            eval_q  <= eval_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            resp_q  <= resp_d;
            oones_q <= oones_d;
            chal_q  <= chal_d;
        end
    end

    assign opulse     = pulse_q;
    assign ochallenge = chal_q;
    assign obusy      = busy_q;
    assign ovalid     = valid_q;
    assign oresp      = resp_q;
    assign oones      = oones_q;

endmodule
